// File: rtl/rsh_pkg.sv
// rsh_pkg: shared widths, shift amount and word type for the byte right shifter
package rsh_pkg;
  localparam int DATA_W = 16;
  localparam int RSH_AMT = 8;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/rsh_core.sv
// rsh_core: combinational log barrel logical right shifter steered by SHIFT bits
module rsh_core #(
  parameter int N = 4,
  parameter int SHIFT = 8
) (
  input  logic [2**N-1:0] a,
  output logic [2**N-1:0] y
);
  localparam logic [N:0] SH = (N+1)'(SHIFT);
  logic [2**N-1:0] s [N+1];
  assign s[0] = a;
  for (genvar i = 0; i < N; i++) begin : g_stage
    assign s[i+1] = SH[i] ? s[i] >> (2**i) : s[i];
  end
  assign y = SH[N] ? '0 : s[N];
endmodule

// File: rtl/rsh_eight_unit.sv
// rsh_eight_unit: registered fixed logical right shift with valid flag
module rsh_eight_unit
  import rsh_pkg::*;
#(
  parameter int N = 4,
  parameter int SHIFT = RSH_AMT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2**N-1:0] a,
  output logic            out_valid,
  output logic [2**N-1:0] b
);
  logic [2**N-1:0] shifted;
  rsh_core #(.N(N), .SHIFT(SHIFT)) u_core (.a(a), .y(shifted));
  // capture the shifted word only on valid input; the flag tracks in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) b <= shifted;
    end
  end
endmodule

// File: tb/tb_rsh_eight_unit.sv
// tb_rsh_eight_unit: randomized and directed checks against an arithmetic reference
module tb_rsh_eight_unit;
  import rsh_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  word_t a = '0;
  logic out_valid;
  word_t b;
  int vectors = 0;
  int errs = 0;

  rsh_eight_unit dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .out_valid(out_valid), .b(b));

  always #5 clk = ~clk;

  function automatic word_t ref_shift(input word_t x);
    return word_t'(int'(x) / 256);
  endfunction

  task automatic drive(input logic v, input word_t x);
    @(negedge clk);
    in_valid = v;
    a = x;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hABCD);
      vectors++;
      if (b !== 16'h0000 || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold: b=%h ov=%b want b=0000 ov=0", b, out_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'hABCD);
    vectors++;
    if (b !== 16'h00AB || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL reset_release: b=%h ov=%b want b=00ab ov=1", b, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_async: b=%h ov=%b want b=0000 ov=0", b, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    word_t ins [10] = '{16'hABCD, 16'h1234, 16'h0013, 16'hFFFB, 16'hFFEE,
                        16'h0000, 16'hFFFF, 16'h0100, 16'h00FF, 16'h8000};
    word_t exps [10] = '{16'h00AB, 16'h0012, 16'h0000, 16'h00FF, 16'h00FF,
                         16'h0000, 16'h00FF, 16'h0001, 16'h0000, 16'h0080};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ins[i]);
      vectors++;
      if (b !== exps[i] || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL directed[%0d] a=%h: b=%h ov=%b want b=%h ov=1", i, ins[i], b, out_valid, exps[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i == 2 ? 16'hxxxx : 16'h5555);
      vectors++;
      if (b !== 16'h00AB || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL hold[%0d]: b=%h ov=%b want b=00ab ov=0", i, b, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t x;
    for (int i = 0; i < 6; i++) begin
      x = word_t'($urandom);
      drive(1'b1, x);
      vectors++;
      if (b !== ref_shift(x) || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL stream[%0d] a=%h: b=%h ov=%b want b=%h ov=1", i, x, b, out_valid, ref_shift(x));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stream_reset: b=%h ov=%b want b=0000 ov=0", b, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 16'h7777);
    vectors++;
    if (b !== 16'h0000 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_idle: b=%h ov=%b want b=0000 ov=0", b, out_valid);
    end
    x = word_t'($urandom) | 16'h0100;
    drive(1'b1, x);
    vectors++;
    if (b !== ref_shift(x) || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL post_reset_first: b=%h ov=%b want b=%h ov=1", b, out_valid, ref_shift(x));
    end
  endtask

  task automatic test_random();
    word_t x;
    word_t exp_b = b;
    logic v;
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      x = word_t'($urandom);
      if (v) exp_b = ref_shift(x);
      drive(v, x);
      vectors++;
      if (b !== exp_b || out_valid !== v) begin
        errs++;
        $display("FAIL random[%0d] v=%b a=%h: b=%h ov=%b want b=%h ov=%b", i, v, x, b, out_valid, exp_b, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
